// File: rtl/w25q_flash_target_if.sv
// Bus bundle for the W25Q flash target: the SPI pins seen by the flash and the
// word-read port toward the backing memory.
//   slave  : the flash target (drives miso/oe and memory requests)
//   master : the SPI host plus memory responder (drives sck/cs/mosi and read data)
interface w25q_flash_target_if #(
    parameter int unsigned XLEN = 32
);
    logic            spi_sck;
    logic            spi_cs;
    logic            spi_mosi;
    logic            spi_miso;
    logic            spi_miso_oe;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  spi_sck, spi_cs, spi_mosi, mem_rvalid_i, mem_rdata_i,
        output spi_miso, spi_miso_oe, mem_req_o, mem_addr_o
    );

    modport master (
        output spi_sck, spi_cs, spi_mosi, mem_rvalid_i, mem_rdata_i,
        input  spi_miso, spi_miso_oe, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/w25q_flash_target.sv
// SPI flash responder emulating a W25Q part for JEDEC-ID (0x9F) and fast read (0x0B).
// SPI inputs are oversampled in clk_i; read data is fetched a word at a time from memory.
// Ports:
//   clk_i          system clock
//   arstn_i        asynchronous reset, active low
//   bus            SPI pins + word-read memory port (slave side)
//   busy_o         high while synchronized cs is low
//   err_underrun_o sticky: a data byte was due before its word arrived
module w25q_flash_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int unsigned XLEN        = 32
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    w25q_flash_target_if.slave bus,
    output logic               busy_o,
    output logic               err_underrun_o
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_JEDEC  = 3'd2;
    localparam logic [2:0] ST_ADDR   = 3'd3;
    localparam logic [2:0] ST_DUMMY  = 3'd4;
    localparam logic [2:0] ST_DATA   = 3'd5;
    localparam logic [2:0] ST_IGNORE = 3'd6;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_prev, cs_prev;
    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    logic [2:0]  state_q;
    logic [4:0]  bit_cnt_q;
    logic [6:0]  cmd_sr_q;
    logic [23:0] addr_q;
    logic [23:0] out_sr_q;     // response bits, MSB goes out next; refills with ones
    logic        miso_q, oe_q, req_q;
    logic [23:0] req_addr_q;
    logic        pending_q;    // one memory request in flight
    logic        discard_q;    // the in-flight response is stale and must be dropped
    logic        owed_q;       // a word was needed while memory was busy
    logic [21:0] owed_word_q;
    logic [31:0] buf_q;
    logic        buf_valid_q;
    logic [21:0] buf_tag_q;    // word address the buffer holds (or is waiting for)
    logic        err_q;

    logic [23:0] new_addr;
    logic        addr_done, byte_start, need_req, mem_busy, byte_ok;
    logic [21:0] need_word;
    logic [7:0]  lane;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.mem_req_o   = req_q;
    assign bus.mem_addr_o  = {{(XLEN-24){1'b0}}, req_addr_q};
    assign busy_o          = ~cs_s;
    assign err_underrun_o  = err_q;

    always_comb begin
        new_addr   = {addr_q[22:0], mosi_s};
        addr_done  = ~cs_s && (state_q == ST_ADDR) && sck_rise && (bit_cnt_q == 5'd23);
        byte_start = ~cs_s && (state_q == ST_DATA) && sck_fall && (bit_cnt_q[2:0] == 3'd0);
        need_req   = addr_done || (byte_start && (addr_q[1:0] == 2'd3));
        need_word  = addr_done ? new_addr[23:2] : addr_q[23:2] + 22'd1;
        // A response arriving this cycle frees the port for a new request.
        mem_busy   = pending_q && ~bus.mem_rvalid_i;
        byte_ok    = buf_valid_q && (buf_tag_q == addr_q[23:2]);
        lane       = buf_q[{addr_q[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            addr_q      <= '0;
            out_sr_q    <= '1;
            miso_q      <= 1'b1;
            oe_q        <= 1'b0;
            req_q       <= 1'b0;
            req_addr_q  <= '0;
            pending_q   <= 1'b0;
            discard_q   <= 1'b0;
            owed_q      <= 1'b0;
            owed_word_q <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            req_q <= 1'b0;

            if (bus.mem_rvalid_i) begin
                pending_q <= 1'b0;
                discard_q <= 1'b0;
                if (!discard_q) begin
                    buf_q       <= bus.mem_rdata_i[31:0];
                    buf_valid_q <= 1'b1;
                end
            end

            if (need_req) begin
                buf_valid_q <= 1'b0;
                buf_tag_q   <= need_word;
                if (mem_busy) begin
                    // Older word still in flight: drop it and issue ours once it lands.
                    owed_q      <= 1'b1;
                    owed_word_q <= need_word;
                    discard_q   <= 1'b1;
                end else begin
                    req_q      <= 1'b1;
                    req_addr_q <= {need_word, 2'b00};
                    pending_q  <= 1'b1;
                end
            end else if (owed_q && !mem_busy && !cs_s) begin
                req_q      <= 1'b1;
                req_addr_q <= {owed_word_q, 2'b00};
                pending_q  <= 1'b1;
                owed_q     <= 1'b0;
            end

            if (cs_rise) begin
                state_q     <= ST_IDLE;
                bit_cnt_q   <= '0;
                addr_q      <= '0;
                miso_q      <= 1'b1;
                oe_q        <= 1'b0;
                buf_valid_q <= 1'b0;
                owed_q      <= 1'b0;
                if (mem_busy) discard_q <= 1'b1;
            end else if (!cs_s) begin
                case (state_q)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_q   <= ST_CMD;
                            bit_cnt_q <= '0;
                            err_q     <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            cmd_sr_q  <= {cmd_sr_q[5:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q <= '0;
                                case ({cmd_sr_q, mosi_s})
                                    8'h9F: begin
                                        state_q  <= ST_JEDEC;
                                        oe_q     <= 1'b1;
                                        out_sr_q <= JEDEC_ID;
                                    end
                                    8'h0B:   state_q <= ST_ADDR;
                                    default: state_q <= ST_IGNORE;
                                endcase
                            end
                        end
                    end
                    ST_JEDEC: begin
                        if (sck_fall) begin
                            miso_q   <= out_sr_q[23];
                            out_sr_q <= {out_sr_q[22:0], 1'b1};
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            addr_q    <= new_addr;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (addr_done) begin
                                bit_cnt_q <= '0;
                                state_q   <= ST_DUMMY;
                                oe_q      <= 1'b1;
                                miso_q    <= 1'b1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sck_rise) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q <= '0;
                                state_q   <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_fall) begin
                            bit_cnt_q <= {2'b00, bit_cnt_q[2:0] + 3'd1};
                            if (byte_start) begin
                                addr_q <= addr_q + 24'd1;
                                if (byte_ok) begin
                                    miso_q   <= lane[7];
                                    out_sr_q <= {lane[6:0], 17'h1FFFF};
                                end else begin
                                    miso_q   <= 1'b1;
                                    out_sr_q <= '1;
                                    err_q    <= 1'b1;
                                end
                            end else begin
                                miso_q   <= out_sr_q[23];
                                out_sr_q <= {out_sr_q[22:0], 1'b1};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_w25q_flash_target.sv
// Directed bench for w25q_flash_target: acts as SPI mode-0 host and as a word memory
// with programmable response latency.
module tb_w25q_flash_target;
    localparam int HALF = 80;  // sck half period in ns (8 clk_i cycles)

    logic clk = 1'b0;
    logic arstn;
    logic busy, err_underrun;
    int   checks = 0;
    int   errors = 0;

    w25q_flash_target_if #(.XLEN(32)) bus ();

    w25q_flash_target #(
        .SYNC_STAGES(2),
        .JEDEC_ID   (24'hEF4018),
        .XLEN       (32)
    ) dut (
        .clk_i         (clk),
        .arstn_i       (arstn),
        .bus           (bus),
        .busy_o        (busy),
        .err_underrun_o(err_underrun)
    );

    always #5 clk = ~clk;

    // Memory responder
    int unsigned mem_lat = 3;
    int          req_n   = 0;
    logic [31:0] req_log [0:15];
    int unsigned cnt     = 0;
    logic        mbusy   = 1'b0;
    logic [31:0] maddr   = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0104: return 32'h1122_3344;
            32'h0000_0108: return 32'h5566_7788;
            32'h00FF_FFFC: return 32'hA1A2_A3A4;
            32'h0000_0000: return 32'hB1B2_B3B4;
            default:       return {8'hC0, a[23:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        bus.mem_rvalid_i <= 1'b0;
        if (bus.mem_req_o) begin
            maddr <= bus.mem_addr_o;
            cnt   <= mem_lat;
            mbusy <= 1'b1;
            if (req_n < 16) req_log[req_n] <= bus.mem_addr_o;
            req_n <= req_n + 1;
        end else if (mbusy) begin
            if (cnt <= 1) begin
                bus.mem_rvalid_i <= 1'b1;
                bus.mem_rdata_i  <= mem_word(maddr);
                mbusy            <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift nbits of tx (from bit 7 down), sampling miso just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spi_mosi = tx[i];
            #HALF;
            rx[i] = bus.spi_miso;
            bus.spi_sck = 1'b1;
            #HALF;
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic frame_begin();
        bus.spi_cs = 1'b0;
        #HALF;
    endtask

    task automatic frame_end();
        #HALF;
        bus.spi_cs = 1'b1;
        #(4 * HALF);
    endtask

    logic [7:0] rx;
    int         n0;
    logic       bad;
    logic [7:0] exp_bytes [0:4];

    initial begin
        arstn        = 1'b0;
        bus.spi_cs   = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        #30;
        check("rst_miso", 32'(bus.spi_miso), 32'd1);
        check("rst_oe", 32'(bus.spi_miso_oe), 32'd0);
        check("rst_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_addr", bus.mem_addr_o, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_underrun), 32'd0);
        arstn = 1'b1;
        #40;

        // Idle: cs high, sck toggling for 100 clk cycles
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #20;
            bus.spi_sck = ~bus.spi_sck;
            if (bus.spi_miso !== 1'b1 || bus.spi_miso_oe !== 1'b0 || bus.mem_req_o !== 1'b0)
                bad = 1'b1;
        end
        bus.spi_sck = 1'b0;
        #40;
        check("idle_bad", 32'(bad), 32'd0);
        check("idle_reqs", 32'(req_n), 32'd0);

        // JEDEC ID
        n0 = req_n;
        frame_begin();
        spi_byte(8'h9F, rx);
        check("jedec_busy", 32'(busy), 32'd1);
        check("jedec_oe", 32'(bus.spi_miso_oe), 32'd1);
        spi_byte(8'h00, rx); check("jedec_b0", 32'(rx), 32'hEF);
        spi_byte(8'h00, rx); check("jedec_b1", 32'(rx), 32'h40);
        spi_byte(8'h00, rx); check("jedec_b2", 32'(rx), 32'h18);
        spi_byte(8'h00, rx); check("jedec_pad", 32'(rx), 32'hFF);
        frame_end();
        check("jedec_reqs", 32'(req_n - n0), 32'd0);
        check("jedec_end_oe", 32'(bus.spi_miso_oe), 32'd0);
        check("jedec_end_miso", 32'(bus.spi_miso), 32'd1);
        check("jedec_end_busy", 32'(busy), 32'd0);

        // Fast read at 0x000104
        exp_bytes[0] = 8'h44; exp_bytes[1] = 8'h33; exp_bytes[2] = 8'h22;
        exp_bytes[3] = 8'h11; exp_bytes[4] = 8'h88;
        n0 = req_n;
        frame_begin();
        spi_byte(8'h0B, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h01, rx);
        spi_byte(8'h04, rx);
        spi_byte(8'h00, rx);
        for (int i = 0; i < 5; i++) begin
            spi_byte(8'h00, rx);
            check($sformatf("fr_byte%0d", i), 32'(rx), 32'(exp_bytes[i]));
        end
        check("fr_oe", 32'(bus.spi_miso_oe), 32'd1);
        frame_end();
        check("fr_nreq", 32'(req_n - n0), 32'd2);
        check("fr_req0", req_log[n0], 32'h0000_0104);
        check("fr_req1", req_log[n0 + 1], 32'h0000_0108);
        check("fr_err", 32'(err_underrun), 32'd0);

        // Fast read wrapping past 0xFFFFFF
        exp_bytes[0] = 8'hA2; exp_bytes[1] = 8'hA1; exp_bytes[2] = 8'hB4;
        n0 = req_n;
        frame_begin();
        spi_byte(8'h0B, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFE, rx);
        spi_byte(8'h00, rx);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, rx);
            check($sformatf("wrap_byte%0d", i), 32'(rx), 32'(exp_bytes[i]));
        end
        frame_end();
        check("wrap_nreq", 32'(req_n - n0), 32'd2);
        check("wrap_req0", req_log[n0], 32'h00FF_FFFC);
        check("wrap_req1", req_log[n0 + 1], 32'h0000_0000);

        // Underrun: word arrives after the first data byte has started
        mem_lat = 200;
        frame_begin();
        spi_byte(8'h0B, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h01, rx);
        spi_byte(8'h04, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx); check("ur_byte0", 32'(rx), 32'hFF);
        spi_byte(8'h00, rx); check("ur_byte1", 32'(rx), 32'h33);
        check("ur_err", 32'(err_underrun), 32'd1);
        frame_end();
        check("ur_err_sticky", 32'(err_underrun), 32'd1);
        mem_lat = 3;

        // New frame clears the error; abort after 12 address bits
        n0 = req_n;
        frame_begin();
        check("ur_err_clr", 32'(err_underrun), 32'd0);
        spi_byte(8'h0B, rx);
        spi_byte(8'h00, rx);
        spi_bits(8'h10, 4, rx);
        frame_end();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_oe", 32'(bus.spi_miso_oe), 32'd0);
        check("abort_reqs", 32'(req_n - n0), 32'd0);

        // JEDEC ID again after the aborted frame
        frame_begin();
        spi_byte(8'h9F, rx);
        spi_byte(8'h00, rx); check("jedec2_b0", 32'(rx), 32'hEF);
        spi_byte(8'h00, rx); check("jedec2_b1", 32'(rx), 32'h40);
        spi_byte(8'h00, rx); check("jedec2_b2", 32'(rx), 32'h18);
        frame_end();

        // Unsupported command 0x03: stay silent
        n0  = req_n;
        bad = 1'b0;
        frame_begin();
        spi_byte(8'h03, rx);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, rx);
            if (bus.spi_miso_oe !== 1'b0) bad = 1'b1;
        end
        check("ign_oe", 32'(bad), 32'd0);
        check("ign_miso", 32'(rx), 32'hFF);
        frame_end();
        check("ign_reqs", 32'(req_n - n0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
